// File: rtl/cpu_timing.sv
// CPU clock-enable and frame timing generator for the Z80 core wrapper.
// Produces complementary cep/cen enables, a T-state counter and a fixed-width frame interrupt.

module cpu_timing #(
    parameter int unsigned CLK_DIV   = 6,
    parameter int unsigned FRAME_T   = 80000,
    parameter int unsigned INT_WIDTH = 32
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       stall,
    output logic                       cep,
    output logic                       cen,
    output logic                       int_n,
    output logic                       frame,
    output logic [$clog2(FRAME_T)-1:0] tstate
);

    localparam int unsigned DW = $clog2(CLK_DIV);
    localparam int unsigned TW = $clog2(FRAME_T);

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2 - 1);
    localparam logic [TW-1:0] T_LAST   = TW'(FRAME_T - 1);
    localparam logic [TW-1:0] T_INT    = TW'(INT_WIDTH);

    logic [DW-1:0] div_q, div_d;
    logic [TW-1:0] tstate_q, tstate_d;
    logic          cep_q, cep_d;
    logic          cen_q, cen_d;
    logic          int_n_q, int_n_d;
    logic          frame_q, frame_d;

    always_comb begin
        div_d    = div_q;
        tstate_d = tstate_q;
        int_n_d  = int_n_q;
        cep_d    = 1'b0;
        cen_d    = 1'b0;
        frame_d  = 1'b0;

        if (div_q == DIV_LAST) begin
            // Stall is only honoured here, so a T-state in progress always completes.
            if (!stall) begin
                div_d = '0;
                cep_d = 1'b1;
                if (tstate_q == T_LAST) begin
                    tstate_d = '0;
                    frame_d  = 1'b1;
                end else begin
                    tstate_d = tstate_q + 1'b1;
                end
                int_n_d = !(tstate_d < T_INT);
            end
        end else begin
            div_d = div_q + 1'b1;
        end

        if (div_q == DIV_HALF) begin
            cen_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            div_q    <= '0;
            tstate_q <= T_LAST;
            cep_q    <= 1'b0;
            cen_q    <= 1'b0;
            int_n_q  <= 1'b1;
            frame_q  <= 1'b0;
        end else begin
            div_q    <= div_d;
            tstate_q <= tstate_d;
            cep_q    <= cep_d;
            cen_q    <= cen_d;
            int_n_q  <= int_n_d;
            frame_q  <= frame_d;
        end
    end

    assign cep    = cep_q;
    assign cen    = cen_q;
    assign int_n  = int_n_q;
    assign frame  = frame_q;
    assign tstate = tstate_q;

endmodule

// File: tb/tb_cpu_timing.sv
// Directed bench for cpu_timing with CLK_DIV=6, FRAME_T=100, INT_WIDTH=4.

module tb_cpu_timing;

    logic       clock;
    logic       reset;
    logic       stall;
    logic       cep;
    logic       cen;
    logic       int_n;
    logic       frame;
    logic [6:0] tstate;

    int checks;
    int errors;
    int clk_n;
    int cep_cnt;
    int frame_cnt;
    int last_cep;
    int tog_ceps;
    bit last_was_cep;
    bit found;

    cpu_timing #(
        .CLK_DIV  (6),
        .FRAME_T  (100),
        .INT_WIDTH(4)
    ) dut (
        .clock (clock),
        .reset (reset),
        .stall (stall),
        .cep   (cep),
        .cen   (cen),
        .int_n (int_n),
        .frame (frame),
        .tstate(tstate)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One system clock; sample 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
        clk_n++;
        if (cep) cep_cnt++;
        if (frame) frame_cnt++;
        check("cep_cen_overlap", {31'b0, cep & cen}, 0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_cep"}, {31'b0, cep}, 0);
        check({tag, "_cen"}, {31'b0, cen}, 0);
        check({tag, "_frame"}, {31'b0, frame}, 0);
        check({tag, "_int_n"}, {31'b0, int_n}, 1);
        check({tag, "_tstate"}, {25'b0, tstate}, 99);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        clk_n     = 0;
        cep_cnt   = 0;
        frame_cnt = 0;
        reset     = 1'b0;
        stall     = 1'b0;

        // Held in reset: outputs stay at reset values.
        repeat (3) begin
            tick();
            check_reset_values("in_reset");
        end

        // Release at a falling edge; next rising edge is clock 1.
        #4;
        reset     = 1'b1;
        clk_n     = 0;
        cep_cnt   = 0;
        frame_cnt = 0;
        for (int n = 1; n <= 12; n++) begin
            tick();
            check("cep_phase", {31'b0, cep}, (n % 6 == 0) ? 1 : 0);
            check("cen_phase", {31'b0, cen}, (n % 6 == 3) ? 1 : 0);
            if (n == 6) begin
                check("first_tstate", {25'b0, tstate}, 0);
                check("first_frame", {31'b0, frame}, 1);
                check("first_int_n", {31'b0, int_n}, 0);
            end
        end
        check("cep2_tstate", {25'b0, tstate}, 1);
        check("cep2_frame", {31'b0, frame}, 0);

        // Free run through cep 101: tstate wraps once more, int_n low for tstate 0..3.
        for (int k = 3; k <= 101; k++) begin
            repeat (6) tick();
            check("run_cep", {31'b0, cep}, 1);
            check("run_tstate", {25'b0, tstate}, (k - 1) % 100);
            check("run_int_n", {31'b0, int_n}, (((k - 1) % 100) < 4) ? 0 : 1);
            check("run_frame", {31'b0, frame}, (k == 101) ? 1 : 0);
        end
        check("cep_count", cep_cnt, 101);
        check("frame_count", frame_cnt, 2);

        // Stall raised at div=2: that T-state's cen still fires, then everything freezes.
        tick();
        tick();
        stall = 1'b1;
        tick();
        check("stall_cen", {31'b0, cen}, 1);
        repeat (19) begin
            tick();
            check("stall_no_cep", {31'b0, cep}, 0);
            check("stall_no_cen", {31'b0, cen}, 0);
            check("stall_tstate", {25'b0, tstate}, 0);
        end
        stall = 1'b0;
        tick();
        check("unstall_cep", {31'b0, cep}, 1);
        check("unstall_tstate", {25'b0, tstate}, 1);

        // Advance to tstate 99, then stall across the frame boundary.
        for (int t = 2; t <= 99; t++) repeat (6) tick();
        check("pre_wrap_cep", {31'b0, cep}, 1);
        check("pre_wrap_tstate", {25'b0, tstate}, 99);
        stall = 1'b1;
        repeat (10) begin
            tick();
            check("wrap_stall_cep", {31'b0, cep}, 0);
            check("wrap_stall_frame", {31'b0, frame}, 0);
            check("wrap_stall_int_n", {31'b0, int_n}, 1);
            check("wrap_stall_tstate", {25'b0, tstate}, 99);
        end
        stall = 1'b0;
        tick();
        check("wrap_cep", {31'b0, cep}, 1);
        check("wrap_frame", {31'b0, frame}, 1);
        check("wrap_int_n", {31'b0, int_n}, 0);
        check("wrap_tstate", {25'b0, tstate}, 0);
        for (int t = 1; t <= 4; t++) begin
            repeat (6) tick();
            check("wrap_run_cep", {31'b0, cep}, 1);
            check("wrap_int_width", {31'b0, int_n}, (t < 4) ? 1'b0 : 1'b1);
        end

        // Stall toggled every clock: cep gap >= CLK_DIV, cep/cen alternate.
        last_cep     = clk_n;
        last_was_cep = 1'b1;
        tog_ceps     = 0;
        for (int i = 0; i < 1000; i++) begin
            stall = ~stall;
            tick();
            if (cep) begin
                tog_ceps++;
                check("toggle_gap", {31'b0, (clk_n - last_cep) >= 6}, 1);
                check("toggle_alt_cep", {31'b0, last_was_cep}, 0);
                last_cep     = clk_n;
                last_was_cep = 1'b1;
            end
            if (cen) begin
                check("toggle_alt_cen", {31'b0, last_was_cep}, 1);
                last_was_cep = 1'b0;
            end
        end
        check("toggle_progress", {31'b0, tog_ceps >= 100}, 1);

        // Run to tstate 2 of a frame (interrupt active), bounded.
        stall = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            tick();
            if (cep && tstate == 7'd2) found = 1'b1;
        end
        check("find_tstate2", {31'b0, found}, 1);
        check("mid_int_int_n", {31'b0, int_n}, 0);

        // Async reset mid-interrupt: takes effect without a clock edge.
        reset = 1'b0;
        #1;
        check_reset_values("async_reset");
        tick();
        tick();
        check_reset_values("async_hold");
        #4;
        reset = 1'b1;
        for (int n = 1; n <= 6; n++) begin
            tick();
            check("rerun_cep", {31'b0, cep}, (n == 6) ? 1 : 0);
        end
        check("rerun_tstate", {25'b0, tstate}, 0);
        check("rerun_int_n", {31'b0, int_n}, 0);
        check("rerun_frame", {31'b0, frame}, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_timing.md
Name: cpu_timing

Overview:
Timing generator directly upstream of the Z80 core wrapper.
- Divides the system clock into the complementary CPU clock enables `cep` and `cen`.
- Counts CPU T-states across a video frame.
- Drives the fixed-width maskable interrupt `int_n` once per frame.
- Provides a `stall` input so video/memory arbitration can freeze the CPU at T-state boundaries.

Parameters:
- CLK_DIV, 6: system clocks per CPU T-state. Must be even and ≥2.
- FRAME_T, 80000: T-states per frame (4 MHz / 50 Hz).
- INT_WIDTH, 32: T-states `int_n` is held low at frame start. Must satisfy 1 ≤ INT_WIDTH < FRAME_T.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (low = reset).
- stall  in  1  high requests CPU freeze; honoured only at T-state boundary.
- cep  out  1  one-clock pulse: CPU rising-edge enable.
- cen  out  1  one-clock pulse: CPU falling-edge enable.
- int_n  out  1  active-low interrupt to CPU.
- frame  out  1  one-clock pulse when T-state counter wraps to 0.
- tstate  out  clog2(FRAME_T)  current T-state within frame, 0..FRAME_T-1.

Behaviour:
- Reset (async assert, sync release):
  - div=0, cep=0, cen=0, frame=0, int_n=1.
  - tstate=FRAME_T-1, so the first `cep` wraps the frame and raises an interrupt.
- Divider `div`:
  - Counts 0..CLK_DIV-1 and wraps to 0.
  - Holds at CLK_DIV-1 while `stall` is high.
- All outputs are registered; none is combinational from inputs.
- `cep` generation:
  - `cep` <= 1 for exactly one clock when div==CLK_DIV-1 and stall==0. The same edge wraps div to 0.
  - Otherwise `cep` <= 0.
  - After reset release with stall low, first `cep` is high in clock CLK_DIV (1-based); period CLK_DIV.
- `cen` generation:
  - `cen` <= 1 for exactly one clock when div==CLK_DIV/2-1; otherwise 0.
  - `cen` therefore trails each `cep` by CLK_DIV/2 clocks.
  - `cep` and `cen` are never high together.
- Stall rules:
  - Sampled only at div==CLK_DIV-1. Stall asserted mid-T-state lets the current T-state complete; its `cen` still fires.
  - While stalled: no `cep`, no `cen`; tstate, int_n and frame hold.
  - Stall deasserted while held: next clock issues `cep`.
  - Minimum gap between `cep` pulses is always CLK_DIV clocks.
- T-state counter: updated on the same edge that asserts `cep`.
  - tstate==FRAME_T-1 → 0, and `frame` <= 1 for that one clock.
  - Otherwise tstate+1.
  - `frame` is 0 on every other clock.
- Interrupt:
  - On each `cep` edge, `int_n` <= 0 if the new tstate < INT_WIDTH, else 1.
  - So `int_n` falls with the `cep` that starts T-state 0 and rises with the `cep` that starts T-state INT_WIDTH.
  - Held level during stall.
  - No acknowledge input: the pulse width is fixed regardless of CPU response.
- Reset mid-operation: immediate return to reset values. `int_n` deasserts asynchronously, and any partial frame is discarded.
- Arithmetic: div is clog2(CLK_DIV) bits and tstate is clog2(FRAME_T) bits, both unsigned. Wrap is explicit compare, not natural overflow.

Test Plan:
- Reset release, CLK_DIV=6, stall=0 → first `cep` in clock 6, then every 6 clocks; `cen` at clocks 3, 9, 15…; never coincident; outputs stable at reset values while reset=0.
- FRAME_T=100, INT_WIDTH=4, free run → `frame` and `int_n` fall on 1st `cep`; `int_n` rises on 5th `cep`; next fall on 101st `cep`; tstate sequence 0..99,0; exactly one `frame` pulse per 100 `cep`s.
- Stall asserted at div=2 for 20 clocks → that T-state's `cen` still fires; no `cep`/`cen` during stall; `cep` on the clock after stall drops; tstate advances by exactly 1 across the gap.
- Stall held across tstate 99→0 boundary (FRAME_T=100) → `frame` and `int_n` fall delayed until release; `int_n` low for exactly 4 `cep`s afterward.
- Stall toggled every clock for 1000 clocks → no two `cep` pulses closer than CLK_DIV clocks; `cep`/`cen` strictly alternate.
- Async reset asserted mid-interrupt (int_n=0, tstate=2) → same-cycle `int_n`=1, cep=cen=frame=0, tstate=FRAME_T-1; after release, first `cep` re-raises interrupt at tstate 0.
